// File: rtl/vector_floating_point_writeback_queue.sv
// Writeback queue for the vector FP min/max stage: a fixed-latency tag pipeline follows
// each accepted issue, and the results it captures are buffered in order for the write port.
module vector_floating_point_writeback_queue #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2,
  parameter int VLEN    = 128
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [4:0]                 issue_vd_address,
  input  logic [VLEN-1:0]            result_vd,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [4:0]                 wb_vd_address,
  output logic [VLEN-1:0]            wb_vd,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(DEPTH + LATENCY + 1) + 1;

  logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [4:0]         tag_addr_q [LATENCY];
  logic [4:0]         tag_addr_d [LATENCY];
  logic [4:0]         mem_addr_q [DEPTH];
  logic [VLEN-1:0]    mem_data_q [DEPTH];
  logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [OW-1:0]      count_q, count_d;
  logic [CW-1:0]      inflight_s;
  logic               accept_s, push_s, pop_s;

  // Slots are reserved at issue time: stored entries plus every tag still in flight.
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight_s = inflight_s + CW'(tag_vld_q[i]);
    end
  end

  assign issue_ready = (CW'(count_q) + inflight_s) < CW'(DEPTH);
  assign accept_s    = issue_valid & issue_ready;
  assign push_s      = tag_vld_q[LATENCY-1];
  assign wb_valid    = (count_q != '0);
  assign pop_s       = wb_valid & wb_ready;
  assign occupancy   = count_q;

  always_comb begin
    tag_vld_d[0] = accept_s;
    if (accept_s) begin
      tag_addr_d[0] = issue_vd_address;
    end else begin
      tag_addr_d[0] = 5'd0;
    end
    for (int i = 1; i < LATENCY; i++) begin
      tag_vld_d[i]  = tag_vld_q[i-1];
      tag_addr_d[i] = tag_addr_q[i-1];
    end
    // Pointers wrap naturally because DEPTH is a power of two.
    head_d  = pop_s  ? head_q + PW'(1) : head_q;
    tail_d  = push_s ? tail_q + PW'(1) : tail_q;
    count_d = count_q + OW'(push_s) - OW'(pop_s);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tag_vld_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      tag_vld_q <= tag_vld_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < LATENCY; i++) begin
      tag_addr_q[i] <= tag_addr_d[i];
    end
  end

  // Storage is not cleared on reset; only the pointers and count define what is live.
  always_ff @(posedge clock) begin
    if (push_s && !reset) begin
      mem_addr_q[tail_q] <= tag_addr_q[LATENCY-1];
      mem_data_q[tail_q] <= result_vd;
    end
  end

  always_comb begin
    if (wb_valid) begin
      wb_vd         = mem_data_q[head_q];
      wb_vd_address = mem_addr_q[head_q];
    end else begin
      wb_vd         = '0;
      wb_vd_address = 5'd0;
    end
  end

endmodule
